switch_control_vc_mux: RTL and testbench

- Return-path counterpart of the switch-control demux.
- Arbitrates round-robin among VC planes with pending switch-control work and drives the shared VCPlaneSelector.
- Multiplexes the per-VC route-reservation status from the per-VC SwitchControllers back to the single HFB-facing status bus.
- Enforces a bounded dwell per plane and one idle guard cycle between planes.

---
 rtl/switch_control_vc_mux.sv | 175 +++++++++++++++++
 tb/tb_switch_control_vc_mux.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/switch_control_vc_mux.sv
`default_nettype none
//==============================================================================
// Module   : switch_control_vc_mux
// Purpose  : Return-path VC plane multiplexer for switch control. Picks one
//            requesting VC plane at a time (round-robin), drives the shared
//            VCPlaneSelector, and forwards that plane's route-reservation
//            status to the single HFB-facing status bus. A plane holds the
//            selector for at most MAX_DWELL cycles, and every plane switch
//            passes through one idle guard cycle.
// Ports    :
//   clk                  in   clock, rising edge
//   rst                  in   synchronous active-high reset
//   vcRequest            in   [VC]        per-plane pending switch work
//   planeDone            in   1           current plane's transaction done
//   routeReserveStatusVC in   [VC*INPUTS] per-plane status, plane v at v*INPUTS
//   VCPlaneSelector      out  [VC+1]      active plane, VC = none selected
//   routeReserveStatus   out  [INPUTS]    registered status of active plane
//   planeActive          out  1           high while a plane is active
//   dwellTimeout         out  1           pulse when a plane is evicted
// Revision : 1.0 - initial release
//==============================================================================
module switch_control_vc_mux #(
    parameter int VC        = 4,
    parameter int INPUTS    = 4,
    parameter int MAX_DWELL = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [VC-1:0]          vcRequest,
    input  logic                   planeDone,
    input  logic [VC*INPUTS-1:0]   routeReserveStatusVC,
    output logic [VC:0]            VCPlaneSelector,
    output logic [INPUTS-1:0]      routeReserveStatus,
    output logic                   planeActive,
    output logic                   dwellTimeout
);

    localparam int c_IDXW = (VC > 1) ? $clog2(VC) : 1;
    localparam int c_CNTW = $clog2(MAX_DWELL) + 1;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACTIVE = 2'd1;
    localparam logic [1:0] c_ST_GAP    = 2'd2;

    localparam logic [VC:0]        c_NO_PLANE   = (VC + 1)'(VC);
    localparam logic [c_IDXW-1:0]  c_LAST_RESET = c_IDXW'(VC - 1);
    localparam logic [c_CNTW-1:0]  c_DWELL_LAST = c_CNTW'(MAX_DWELL - 1);
    localparam logic [c_CNTW-1:0]  c_CNT_MAX    = '1;

    logic [1:0]         r_state;
    logic [VC:0]        r_selector;
    logic [INPUTS-1:0]  r_status;
    logic               r_planeActive;
    logic               r_dwellTimeout;
    logic [c_IDXW-1:0]  r_lastGrant;
    logic [c_CNTW-1:0]  r_dwellCnt;

    logic [1:0]         w_stateNext;
    logic [VC:0]        w_selNext;
    logic [INPUTS-1:0]  w_statusNext;
    logic               w_timeoutNext;
    logic [c_IDXW-1:0]  w_lastGrantNext;
    logic [c_CNTW-1:0]  w_cntNext;

    logic               w_anyReq;
    logic [c_IDXW-1:0]  w_winner;
    logic [c_IDXW-1:0]  w_candidate;
    logic [INPUTS-1:0]  w_selStatus;

    assign w_anyReq = |vcRequest;

    // Round-robin search starting just after the last grant. Offsets are
    // walked from farthest to nearest so the nearest requester overwrites
    // the others and wins. The wrap is a true modulo, so VC need not be a
    // power of two.
    always_comb begin
        w_winner    = '0;
        w_candidate = '0;
        for (int i = VC; i >= 1; i--) begin
            w_candidate = c_IDXW'((int'(r_lastGrant) + i) % VC);
            if (vcRequest[w_candidate]) begin
                w_winner = w_candidate;
            end
        end
    end

    // While ACTIVE, r_lastGrant always names the plane being served, so it
    // selects the status slice directly.
    always_comb begin
        w_selStatus = '0;
        for (int v = 0; v < VC; v++) begin
            if (r_lastGrant == c_IDXW'(v)) begin
                w_selStatus = routeReserveStatusVC[v*INPUTS +: INPUTS];
            end
        end
    end

    always_comb begin
        w_stateNext     = r_state;
        w_selNext       = r_selector;
        w_statusNext    = r_status;
        w_timeoutNext   = 1'b0;
        w_lastGrantNext = r_lastGrant;
        w_cntNext       = r_dwellCnt;

        case (r_state)
            // GAP arbitrates exactly like IDLE; it only differs in that it
            // is entered unconditionally for a single cycle after ACTIVE.
            c_ST_IDLE, c_ST_GAP: begin
                w_selNext    = c_NO_PLANE;
                w_statusNext = '0;
                if (w_anyReq) begin
                    w_stateNext     = c_ST_ACTIVE;
                    w_selNext       = {{(VC + 1 - c_IDXW){1'b0}}, w_winner};
                    w_lastGrantNext = w_winner;
                    w_cntNext       = '0;
                end else begin
                    w_stateNext = c_ST_IDLE;
                end
            end

            c_ST_ACTIVE: begin
                w_statusNext = w_selStatus;
                if (r_dwellCnt != c_CNT_MAX) begin
                    w_cntNext = r_dwellCnt + 1'b1;
                end
                // planeDone wins over a coincident dwell expiry, so no
                // timeout is flagged when the plane finished on its own.
                if (planeDone) begin
                    w_stateNext  = c_ST_GAP;
                    w_selNext    = c_NO_PLANE;
                    w_statusNext = '0;
                end else if (r_dwellCnt == c_DWELL_LAST) begin
                    w_stateNext   = c_ST_GAP;
                    w_selNext     = c_NO_PLANE;
                    w_statusNext  = '0;
                    w_timeoutNext = 1'b1;
                end
            end

            default: begin
                w_stateNext  = c_ST_IDLE;
                w_selNext    = c_NO_PLANE;
                w_statusNext = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_ST_IDLE;
            r_selector     <= c_NO_PLANE;
            r_status       <= '0;
            r_planeActive  <= 1'b0;
            r_dwellTimeout <= 1'b0;
            r_lastGrant    <= c_LAST_RESET;
            r_dwellCnt     <= '0;
        end else begin
            r_state        <= w_stateNext;
            r_selector     <= w_selNext;
            r_status       <= w_statusNext;
            r_planeActive  <= (w_stateNext == c_ST_ACTIVE);
            r_dwellTimeout <= w_timeoutNext;
            r_lastGrant    <= w_lastGrantNext;
            r_dwellCnt     <= w_cntNext;
        end
    end

    assign VCPlaneSelector    = r_selector;
    assign routeReserveStatus = r_status;
    assign planeActive        = r_planeActive;
    assign dwellTimeout       = r_dwellTimeout;

endmodule
`default_nettype wire

// File: tb/tb_switch_control_vc_mux.sv
`default_nettype none
//==============================================================================
// Module   : tb_switch_control_vc_mux
// Purpose  : Self-checking bench for switch_control_vc_mux. Each step drives
//            inputs on the falling edge, pushes the expected post-edge
//            outputs to a scoreboard queue, and pops/compares them after the
//            rising edge. Directed checks cover grant order, status latency,
//            dwell eviction and reset recovery.
// Revision : 1.0 - initial release
//==============================================================================
module tb_switch_control_vc_mux;

    localparam int VC        = 4;
    localparam int INPUTS    = 4;
    localparam int MAX_DWELL = 16;

    logic                 clk;
    logic                 rst;
    logic [VC-1:0]        vcRequest;
    logic                 planeDone;
    logic [VC*INPUTS-1:0] routeReserveStatusVC;
    logic [VC:0]          VCPlaneSelector;
    logic [INPUTS-1:0]    routeReserveStatus;
    logic                 planeActive;
    logic                 dwellTimeout;

    switch_control_vc_mux #(
        .VC        (VC),
        .INPUTS    (INPUTS),
        .MAX_DWELL (MAX_DWELL)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .vcRequest            (vcRequest),
        .planeDone            (planeDone),
        .routeReserveStatusVC (routeReserveStatusVC),
        .VCPlaneSelector      (VCPlaneSelector),
        .routeReserveStatus   (routeReserveStatus),
        .planeActive          (planeActive),
        .dwellTimeout         (dwellTimeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [VC:0]       sel;
        logic [INPUTS-1:0] status;
        logic              act;
        logic              to;
    } exp_t;

    exp_t sbq[$];

    int nChecks = 0;
    int nErrors = 0;

    // Reference model of the arbiter, held as the state after the last edge.
    int                mState = 0;   // 0 idle, 1 active, 2 gap
    int                mLast  = VC - 1;
    int                mCnt   = 0;
    logic [VC:0]       mSel   = 5'(VC);
    logic [INPUTS-1:0] mStatus = '0;
    logic              mAct   = 1'b0;
    logic              mTo    = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp)
        else begin
            nErrors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelUpdate(input logic r, input logic [VC-1:0] req,
                               input logic done, input logic [VC*INPUTS-1:0] sv);
        if (r) begin
            mState = 0; mSel = 5'(VC); mLast = VC - 1; mCnt = 0;
            mStatus = '0; mTo = 1'b0;
        end else if (mState != 1) begin
            mSel = 5'(VC); mStatus = '0; mTo = 1'b0; mState = 0;
            for (int k = 1; k <= VC; k++) begin
                int c;
                c = (mLast + k) % VC;
                if (req[2'(c)]) begin
                    mState = 1; mSel = 5'(c); mLast = c; mCnt = 0;
                    break;
                end
            end
        end else begin
            mTo = 1'b0;
            if (done) begin
                mState = 2; mSel = 5'(VC); mStatus = '0;
            end else if (mCnt == MAX_DWELL - 1) begin
                mState = 2; mSel = 5'(VC); mStatus = '0; mTo = 1'b1;
            end else begin
                mStatus = 4'(sv >> (mLast * INPUTS));
                mCnt++;
            end
        end
        mAct = (mState == 1);
    endtask

    task automatic step(input logic r, input logic [VC-1:0] req,
                        input logic done, input logic [VC*INPUTS-1:0] sv);
        exp_t e;
        @(negedge clk);
        rst = r; vcRequest = req; planeDone = done; routeReserveStatusVC = sv;
        modelUpdate(r, req, done, sv);
        e.sel = mSel; e.status = mStatus; e.act = mAct; e.to = mTo;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk("sb_sel",    32'(VCPlaneSelector),    32'(e.sel));
        chk("sb_status", 32'(routeReserveStatus), 32'(e.status));
        chk("sb_active", 32'(planeActive),        32'(e.act));
        chk("sb_tmo",    32'(dwellTimeout),       32'(e.to));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int          rec[9];
        int          expSeq[9];
        int          nRec;
        logic [VC:0] prevSel;
        int          cnt;
        int          toCnt;
        logic        gapSeen;

        expSeq = '{0, 4, 1, 4, 2, 4, 3, 4, 0};
        rst = 1'b1; vcRequest = '0; planeDone = 1'b0; routeReserveStatusVC = '0;

        // Reset, then idle with no requests.
        step(1'b1, 4'b0000, 1'b0, 16'h0);
        step(1'b1, 4'b0000, 1'b0, 16'h0);
        repeat (10) step(1'b0, 4'b0000, 1'b1, 16'hFFFF);
        chk("idle_sel", 32'(VCPlaneSelector), 32'd4);

        // Fairness: all requesting, planeDone on the third ACTIVE cycle.
        prevSel = 5'd4;
        nRec = 0;
        for (int k = 0; k < 60 && nRec < 9; k++) begin
            step(1'b0, 4'b1111, (mState == 1 && mCnt == 2), 16'h1234);
            if (VCPlaneSelector != prevSel) begin
                rec[nRec] = int'(VCPlaneSelector);
                nRec++;
                prevSel = VCPlaneSelector;
            end
        end
        chk("fair_count", 32'(nRec), 32'd9);
        for (int i = 0; i < 9; i++) chk("fair_seq", 32'(rec[i]), 32'(expSeq[i]));

        // Status forwarding from plane 2 only, 1-cycle latency.
        step(1'b1, 4'b0000, 1'b0, 16'h0);
        step(1'b0, 4'b0100, 1'b0, 16'hFAFF);
        step(1'b0, 4'b0100, 1'b0, 16'hFAFF);
        chk("st_sel", 32'(VCPlaneSelector), 32'd2);
        chk("st_val", 32'(routeReserveStatus), 32'hA);
        step(1'b0, 4'b0100, 1'b0, 16'hF5FF);
        chk("st_latency", 32'(routeReserveStatus), 32'h5);
        step(1'b0, 4'b0000, 1'b0, 16'hF5FF);
        chk("st_reqdrop", 32'(planeActive), 32'd1);
        step(1'b0, 4'b0000, 1'b1, 16'hF5FF);
        chk("st_gap_sel", 32'(VCPlaneSelector), 32'd4);
        chk("st_gap_stat", 32'(routeReserveStatus), 32'h0);
        step(1'b0, 4'b0000, 1'b0, 16'hF5FF);

        // Dwell eviction: single requester, no planeDone.
        step(1'b1, 4'b0000, 1'b0, 16'h0);
        cnt = 0; toCnt = 0;
        for (int k = 0; k < 40; k++) begin
            step(1'b0, 4'b0010, 1'b0, 16'h00C0);
            if (planeActive) cnt++;
            if (dwellTimeout) begin
                toCnt++;
                break;
            end
        end
        chk("dwell_len", 32'(cnt), 32'd16);
        chk("dwell_to", 32'(toCnt), 32'd1);
        chk("dwell_gap_sel", 32'(VCPlaneSelector), 32'd4);
        step(1'b0, 4'b0010, 1'b0, 16'h00C0);
        chk("dwell_regrant", 32'(VCPlaneSelector), 32'd1);
        chk("dwell_to_clr", 32'(dwellTimeout), 32'd0);

        // planeDone coinciding with the final dwell cycle: no timeout.
        step(1'b1, 4'b0000, 1'b0, 16'h0);
        cnt = 0; toCnt = 0; gapSeen = 1'b0;
        for (int k = 0; k < 40 && !gapSeen; k++) begin
            step(1'b0, 4'b0010, (mState == 1 && mCnt == MAX_DWELL - 1), 16'h0030);
            if (dwellTimeout) toCnt++;
            if (planeActive) cnt++;
            else if (cnt > 0) gapSeen = 1'b1;
        end
        chk("done15_len", 32'(cnt), 32'd16);
        chk("done15_to", 32'(toCnt), 32'd0);
        chk("done15_gap", 32'(gapSeen), 32'd1);

        // Reset in the middle of ACTIVE on plane 3.
        step(1'b1, 4'b0000, 1'b0, 16'h0);
        step(1'b0, 4'b1000, 1'b0, 16'h7000);
        step(1'b0, 4'b1000, 1'b0, 16'h7000);
        chk("rst_pre_sel", 32'(VCPlaneSelector), 32'd3);
        step(1'b1, 4'b1111, 1'b0, 16'h7000);
        chk("rst_sel", 32'(VCPlaneSelector), 32'd4);
        chk("rst_status", 32'(routeReserveStatus), 32'h0);
        chk("rst_active", 32'(planeActive), 32'd0);
        step(1'b0, 4'b1111, 1'b0, 16'h7000);
        chk("rst_first_grant", 32'(VCPlaneSelector), 32'd0);

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule
`default_nettype wire
